// File: rtl/shift_reg_univ_if.sv
// Signal bundle for shift_reg_univ: mode/data/burst controls in, contents and status out.
interface shift_reg_univ_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    logic             en;
    logic [2:0]       mode;
    logic [WIDTH-1:0] d;
    logic             sin_l;
    logic             sin_r;
    logic             start;
    logic [CNT_W-1:0] bcnt;
    logic             bdir;
    logic [WIDTH-1:0] q;
    logic             sout_l;
    logic             sout_r;
    logic             busy;
    logic             done;

    modport master (
        output en, mode, d, sin_l, sin_r, start, bcnt, bdir,
        input  q, sout_l, sout_r, busy, done
    );

    modport slave (
        input  en, mode, d, sin_l, sin_r, start, bcnt, bdir,
        output q, sout_l, sout_r, busy, done
    );
endinterface

// File: rtl/shift_reg_univ.sv
// Universal WIDTH-bit register: load/shift/rotate/clear, plus an optional
// autonomous rotate-burst engine enabled by defining SHREG_BURST_EN.
module shift_reg_univ #(
    parameter int               WIDTH     = 8,
    parameter int               CNT_W     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input logic             clk,
    input logic             rst,
    shift_reg_univ_if.slave bus
);
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] mode_res;
    logic [WIDTH-1:0] rot_l, rot_r;

    assign rot_l = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
    assign rot_r = {q_q[0], q_q[WIDTH-1:1]};

    always_comb begin
        mode_res = q_q;
        case (bus.mode)
            3'b000: mode_res = q_q;
            3'b001: mode_res = bus.d;
            3'b010: mode_res = {q_q[WIDTH-2:0], bus.sin_l};
            3'b011: mode_res = {bus.sin_r, q_q[WIDTH-1:1]};
            3'b100: mode_res = rot_l;
            3'b101: mode_res = rot_r;
            3'b110: mode_res = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
            3'b111: mode_res = '0;
            default: mode_res = q_q;
        endcase
    end

`ifdef SHREG_BURST_EN
    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic             done_q, done_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        done_d  = 1'b0;
        q_d     = q_q;
        case (state_q)
            IDLE: begin
                // An accepted start owns the edge: q holds and mode is ignored.
                if (bus.start) begin
                    if (bus.bcnt == '0) begin
                        done_d = 1'b1;
                    end else begin
                        cnt_d   = bus.bcnt;
                        dir_d   = bus.bdir;
                        state_d = RUN;
                    end
                end else if (bus.en) begin
                    q_d = mode_res;
                end
            end
            RUN: begin
                if (bus.en) begin
                    q_d   = dir_q ? rot_r : rot_l;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q     <= RESET_VAL;
            state_q <= IDLE;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            q_q     <= q_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy = (state_q == RUN);
    assign bus.done = done_q;
`else
    logic unused_burst;
    assign unused_burst = ^{bus.start, bus.bcnt, bus.bdir};

    always_comb begin
        q_d = bus.en ? mode_res : q_q;
    end

    always_ff @(posedge clk) begin
        if (rst) q_q <= RESET_VAL;
        else     q_q <= q_d;
    end

    assign bus.busy = 1'b0;
    assign bus.done = 1'b0;
`endif

    assign bus.q      = q_q;
    assign bus.sout_l = q_q[WIDTH-1];
    assign bus.sout_r = q_q[0];
endmodule

// File: tb/tb_shift_reg_univ.sv
// Directed-vector bench for shift_reg_univ; burst checks track SHREG_BURST_EN.
module tb_shift_reg_univ;
    logic clk = 1'b0;
    logic rst;
    int   n_run = 0;
    int   n_fail = 0;

    shift_reg_univ_if #(.WIDTH(8), .CNT_W(4)) bus ();
    shift_reg_univ #(.WIDTH(8), .CNT_W(4), .RESET_VAL(8'h00)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] v);
        bus.en = 1'b1; bus.mode = 3'b001; bus.d = v; bus.start = 1'b0;
        step();
    endtask

    task automatic op(input logic [2:0] m, input logic [7:0] from, input logic [7:0] exp, input string tag);
        load(from);
        bus.mode = m;
        step();
        chk(tag, bus.q, exp);
    endtask

    initial begin
        rst = 1'b1;
        bus.en = 1'b0; bus.mode = 3'b000; bus.d = '0;
        bus.sin_l = 1'b0; bus.sin_r = 1'b0;
        bus.start = 1'b0; bus.bcnt = '0; bus.bdir = 1'b0;
        step(); step();
        rst = 1'b0;
        chk("rst_q", bus.q, 8'h00);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);

        load(8'hA5);
        chk("load", bus.q, 8'hA5);
        bus.en = 1'b0; bus.mode = 3'b111;
        step();
        chk("hold_en0", bus.q, 8'hA5);
        chk("sout_l", bus.sout_l, 1);
        chk("sout_r", bus.sout_r, 1);

        bus.sin_l = 1'b0; bus.sin_r = 1'b1;
        op(3'b010, 8'h81, 8'h02, "shl");
        op(3'b100, 8'h81, 8'h03, "rotl");
        op(3'b011, 8'h81, 8'hC0, "shr");
        op(3'b101, 8'h81, 8'hC0, "rotr");
        op(3'b110, 8'h81, 8'hC0, "asr");
        op(3'b110, 8'h42, 8'h21, "asr_pos");
        op(3'b111, 8'h81, 8'h00, "clr");
        op(3'b000, 8'h81, 8'h81, "mode_hold");
        bus.sin_l = 1'b1;
        op(3'b010, 8'h40, 8'h81, "shl_sin1");
        chk("sout_l_after", bus.sout_l, 1);

`ifdef SHREG_BURST_EN
        // basic burst, mode inputs toggled during RUN
        load(8'h01);
        bus.start = 1'b1; bus.bcnt = 4'd3; bus.bdir = 1'b0; bus.mode = 3'b111;
        step();
        chk("b_acc_q", bus.q, 8'h01);
        chk("b_acc_busy", bus.busy, 1);
        bus.start = 1'b0; bus.mode = 3'b001; bus.d = 8'hFF; bus.bcnt = 4'd9;
        step(); chk("b_q1", bus.q, 8'h02); chk("b_busy1", bus.busy, 1); chk("b_done1", bus.done, 0);
        bus.mode = 3'b111;
        step(); chk("b_q2", bus.q, 8'h04); chk("b_busy2", bus.busy, 1);
        step(); chk("b_q3", bus.q, 8'h08); chk("b_busy3", bus.busy, 0); chk("b_done3", bus.done, 1);
        bus.en = 1'b0;
        step(); chk("b_done_off", bus.done, 0); chk("b_q_after", bus.q, 8'h08);

        // stall two cycles mid-burst
        load(8'h01);
        bus.start = 1'b1; bus.bcnt = 4'd3; bus.bdir = 1'b0; bus.mode = 3'b000;
        step(); bus.start = 1'b0;
        step(); chk("s_q1", bus.q, 8'h02);
        bus.en = 1'b0;
        step(); chk("s_stall1", bus.q, 8'h02); chk("s_busy_st", bus.busy, 1);
        step(); chk("s_stall2", bus.q, 8'h02); chk("s_done_st", bus.done, 0);
        bus.en = 1'b1;
        step(); chk("s_q2", bus.q, 8'h04); chk("s_busy2", bus.busy, 1);
        step(); chk("s_q3", bus.q, 8'h08); chk("s_done3", bus.done, 1);
        step(); chk("s_done_off", bus.done, 0);

        // right burst
        load(8'h01);
        bus.start = 1'b1; bus.bcnt = 4'd2; bus.bdir = 1'b1; bus.mode = 3'b000;
        step(); bus.start = 1'b0; bus.bdir = 1'b0;
        step(); chk("r_q1", bus.q, 8'h80);
        step(); chk("r_q2", bus.q, 8'h40); chk("r_done", bus.done, 1);

        // bcnt = 0
        load(8'h5A);
        bus.start = 1'b1; bus.bcnt = 4'd0; bus.mode = 3'b111;
        step(); chk("z_q", bus.q, 8'h5A); chk("z_busy", bus.busy, 0); chk("z_done", bus.done, 1);
        bus.start = 1'b0; bus.mode = 3'b000;
        step(); chk("z_done_off", bus.done, 0);

        // reset aborts a running burst
        load(8'h01);
        bus.start = 1'b1; bus.bcnt = 4'd5; bus.bdir = 1'b0; bus.mode = 3'b000;
        step(); bus.start = 1'b0;
        step(); chk("a_q1", bus.q, 8'h02);
        rst = 1'b1;
        step(); chk("a_q", bus.q, 8'h00); chk("a_busy", bus.busy, 0); chk("a_done", bus.done, 0);
        rst = 1'b0;
        step(); chk("a_done2", bus.done, 0); chk("a_busy2", bus.busy, 0);

        // restart accepted in the done cycle
        load(8'h01);
        bus.start = 1'b1; bus.bcnt = 4'd1; bus.mode = 3'b000;
        step(); chk("bb_busy", bus.busy, 1);
        step(); chk("bb_q1", bus.q, 8'h02); chk("bb_done1", bus.done, 1);
        step(); chk("bb_busy2", bus.busy, 1); chk("bb_q_acc", bus.q, 8'h02);
        bus.start = 1'b0;
        step(); chk("bb_q2", bus.q, 8'h04); chk("bb_done2", bus.done, 1);
`else
        load(8'h01);
        bus.start = 1'b1; bus.bcnt = 4'd5; bus.bdir = 1'b0; bus.mode = 3'b000;
        step(); chk("nb_q_hold", bus.q, 8'h01); chk("nb_busy", bus.busy, 0);
        bus.mode = 3'b100;
        step(); chk("nb_q_rotl", bus.q, 8'h02); chk("nb_done", bus.done, 0);
        bus.start = 1'b0; bus.en = 1'b0;
        step(); chk("nb_q_stay", bus.q, 8'h02); chk("nb_busy2", bus.busy, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/shift_reg_univ.md
# shift_reg_univ

Parametrised universal register that generalises the single-bit D flip-flop to a WIDTH-bit word with enable, parallel load, shift, rotate, and clear. An optional burst engine performs a programmed number of back-to-back rotations autonomously with busy/done status. It serves as the general-purpose storage and serialisation element for datapaths that need more than a plain D register.

## Interface
- WIDTH, 8: register width in bits, ≥2
- CNT_W, 4: burst count width; maximum burst length 2^CNT_W−1
- RESET_VAL, {WIDTH{1'b0}}: value loaded into q on reset
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous reset, active-high
- en  in  1  enable for mode operations; also stalls a running burst when low
- mode  in  3  operation select, sampled when en=1 and busy=0
- d  in  WIDTH  parallel load data
- sin_l  in  1  serial input entering bit 0 on shift-left
- sin_r  in  1  serial input entering bit WIDTH−1 on shift-right
- start  in  1  burst request, single-cycle pulse
- bcnt  in  CNT_W  number of burst rotations, sampled with start
- bdir  in  1  burst direction: 0 rotate-left, 1 rotate-right
- q  out  WIDTH  registered contents
- sout_l  out  1  q[WIDTH−1], combinational from q
- sout_r  out  1  q[0], combinational from q
- busy  out  1  burst in progress
- done  out  1  one-cycle pulse at burst completion

## Operation
- Priority per edge: rst > burst engine (busy=1 or start accepted) > mode operation (en=1) > hold.
- Mode codes, executed on the edge when en=1 and busy=0 and start not accepted:
  - 000 hold; 001 load q←d; 010 shift-left q←{q[W−2:0],sin_l}; 011 shift-right q←{sin_r,q[W−1:1]}
  - 100 rotate-left; 101 rotate-right; 110 arithmetic shift-right (MSB replicated); 111 clear q←0
- Burst FSM, states IDLE and RUN:
  - IDLE: start=1 accepted on the edge; bcnt=0 → stay IDLE, done=1 next cycle, q unchanged; bcnt>0 → load counter←bcnt, latch bdir, go RUN, busy=1. q unchanged on the acceptance edge; the mode input is ignored on that edge.
  - RUN: on each edge with en=1, rotate q one bit in the latched direction and decrement the counter; en=0 holds q and the counter.
  - The edge that decrements the counter to 0 performs the last rotate, returns to IDLE, deasserts busy, and pulses done for one cycle.
  - During RUN, start, mode, d, and bcnt are ignored. A new start is accepted from the first IDLE cycle onward, including the cycle in which done=1.
- Reset values: q=RESET_VAL, busy=0, done=0, counter=0, FSM=IDLE. A reset during RUN aborts the burst without a done pulse.

## Timing
- Mode operations have one-cycle latency: the result is visible on q after the sampling edge.
- Burst with start sampled at edge k and bcnt=N>0 (en held high):
  - q changes at edges k+1 through k+N.
  - busy is high from after edge k until edge k+N.
  - done is high for the cycle following edge k+N.
- Every en=0 cycle during RUN adds one cycle to the burst.
- sout_l and sout_r follow q with zero latency.

## Configuration
- Macro SHREG_BURST_EN.
- Defined: the burst engine is as specified above.
- Undefined:
  - start, bcnt, and bdir are ignored.
  - busy and done are tied to 0.
  - No counter or FSM is instantiated.
  - Mode operations are unaffected.

## Test plan
- Reset/load: rst=1 for 2 cycles → q=0x00, busy=0, done=0. Then en=1, mode=001, d=0xA5 → q=0xA5 after one edge. Then en=0 → q holds.
- Shifts, starting from q=0x81:
  - mode 010 with sin_l=0 → 0x02
  - mode 100 → 0x03
  - mode 011 with sin_r=1 → 0xC0
  - mode 110 on 0x81 → 0xC0
  - mode 111 → 0x00
- Burst: q=0x01, start with bcnt=3, bdir=0 → q=0x02, 0x04, 0x08 on consecutive edges; busy high for 3 cycles; done high for 1 cycle. Mode inputs toggled during RUN have no effect.
- Stall: same burst with en=0 for 2 cycles mid-burst → q=0x08 reached 2 cycles later; done still single-cycle.
- Edge cases:
  - bcnt=0 → done pulses the next cycle, q unchanged, busy stays 0.
  - rst asserted during RUN → q=RESET_VAL, busy=0, no done pulse.
- Macro off: start with bcnt=5 → busy and done stay 0, q follows mode operations only.
